branch_resolve_unit: RTL

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/branch_resolve_unit_pkg.sv | 39 +++
 rtl/branch_resolve_unit_if.sv | 42 ++++
 rtl/branch_cmp.sv | 37 +++
 rtl/branch_resolve_unit.sv | 139 +++++++++++++
 4 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// rtl/branch_resolve_unit_pkg.sv - Shared opcodes, func3 encoding and immediate decoders
package branch_resolve_unit_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'd0,
    F3_BNE  = 3'd1,
    F3_RSV2 = 3'd2,
    F3_RSV3 = 3'd3,
    F3_BLT  = 3'd4,
    F3_BGE  = 3'd5,
    F3_BLTU = 3'd6,
    F3_BGEU = 3'd7
  } func3_e;

  typedef struct packed {
    logic taken;
    logic redirect;
    logic misalign;
    logic illegal;
  } res_flags_t;

  // All immediates come back sign-extended to 32 bits; callers widen to XLEN.
  function automatic logic [31:0] imm_b(input logic [31:0] ir);
    return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] ir);
    return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_i(input logic [31:0] ir);
    return {{20{ir[31]}}, ir[31:20]};
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// rtl/branch_resolve_unit_if.sv - Instruction request, result and statistics bus
interface branch_resolve_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic              iVALID;
  logic              oREADY;
  logic [31:0]       iIR;
  logic [XLEN-1:0]   iPC;
  logic [XLEN-1:0]   iREG_OUT1;
  logic [XLEN-1:0]   iREG_OUT2;
  logic              iPRED_TAKEN;
  logic [XLEN-1:0]   iPRED_TARGET;
  logic [4:0]        oRS1;
  logic [4:0]        oRS2;
  logic              oVALID;
  logic              iREADY;
  logic              oTAKEN;
  logic              oREDIRECT;
  logic              oMISALIGN;
  logic              oILLEGAL;
  logic [XLEN-1:0]   oNEXT_PC;
  logic [XLEN-1:0]   oLINK;
  logic              iCNT_CLR;
  logic [CNT_W-1:0]  oBR_CNT;
  logic [CNT_W-1:0]  oMISP_CNT;

  modport master (
    output iVALID, iIR, iPC, iREG_OUT1, iREG_OUT2, iPRED_TAKEN, iPRED_TARGET,
    output iREADY, iCNT_CLR,
    input  oREADY, oRS1, oRS2, oVALID, oTAKEN, oREDIRECT, oMISALIGN, oILLEGAL,
    input  oNEXT_PC, oLINK, oBR_CNT, oMISP_CNT
  );

  modport slave (
    input  iVALID, iIR, iPC, iREG_OUT1, iREG_OUT2, iPRED_TAKEN, iPRED_TARGET,
    input  iREADY, iCNT_CLR,
    output oREADY, oRS1, oRS2, oVALID, oTAKEN, oREDIRECT, oMISALIGN, oILLEGAL,
    output oNEXT_PC, oLINK, oBR_CNT, oMISP_CNT
  );

endinterface

// File: rtl/branch_cmp.sv
// rtl/branch_cmp.sv - Combinational branch condition evaluation selected by func3
module branch_cmp
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  func3_e           func3,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  output logic             cond,
  output logic             legal
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (rs1 == rs2);
  assign lt_s = ($signed(rs1) < $signed(rs2));
  assign lt_u = (rs1 < rs2);

  // func3 2 and 3 are reserved: never taken, flagged illegal.
  always_comb begin
    cond  = 1'b0;
    legal = 1'b1;
    case (func3)
      F3_BEQ:  cond = eq;
      F3_BNE:  cond = !eq;
      F3_BLT:  cond = lt_s;
      F3_BGE:  cond = !lt_s;
      F3_BLTU: cond = lt_u;
      F3_BGEU: cond = !lt_u;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - Resolves branch/JAL/JALR outcome against the front-end
// prediction, one registered result stage, saturating statistics counters.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16,
  parameter int C_EXT = 0
) (
  input  logic                 iCLK,
  input  logic                 iRST_N,
  branch_resolve_unit_if.slave bus
);

  localparam bit CHECK_WORD_ALIGN = (C_EXT == 0);

  logic [6:0]       opcode;
  func3_e           func3;
  logic             is_branch;
  logic             is_jal;
  logic             is_jalr;

  logic [XLEN-1:0]  imm_b_x;
  logic [XLEN-1:0]  imm_j_x;
  logic [XLEN-1:0]  imm_i_x;
  logic [XLEN-1:0]  pc_plus4;
  logic [XLEN-1:0]  jalr_sum;
  logic [XLEN-1:0]  target;

  logic             cond_met;
  logic             f3_legal;
  logic             taken;
  logic             illegal;
  logic             misalign;
  logic             pred_wrong;
  logic             redirect;
  logic             ctrl_legal;

  logic             ready;
  logic             fire;
  logic             valid_q;
  res_flags_t       flags_q;
  logic [XLEN-1:0]  next_pc_q;
  logic [XLEN-1:0]  link_q;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] misp_cnt;

  assign opcode    = bus.iIR[6:0];
  assign func3     = func3_e'(bus.iIR[14:12]);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);

  assign bus.oRS1  = bus.iIR[19:15];
  assign bus.oRS2  = bus.iIR[24:20];

  assign imm_b_x   = XLEN'($signed(imm_b(bus.iIR)));
  assign imm_j_x   = XLEN'($signed(imm_j(bus.iIR)));
  assign imm_i_x   = XLEN'($signed(imm_i(bus.iIR)));
  assign pc_plus4  = bus.iPC + XLEN'(4);
  assign jalr_sum  = bus.iREG_OUT1 + imm_i_x;

  branch_cmp #(
    .XLEN (XLEN)
  ) u_cmp (
    .func3 (func3),
    .rs1   (bus.iREG_OUT1),
    .rs2   (bus.iREG_OUT2),
    .cond  (cond_met),
    .legal (f3_legal)
  );

  always_comb begin
    target = bus.iPC + imm_b_x;
    if (is_jal) begin
      target = bus.iPC + imm_j_x;
    end else if (is_jalr) begin
      target = {jalr_sum[XLEN-1:1], 1'b0};
    end
  end

  assign taken      = is_jal || is_jalr || (is_branch && f3_legal && cond_met);
  assign illegal    = is_branch && !f3_legal;
  assign ctrl_legal = is_jal || is_jalr || (is_branch && f3_legal);
  // target[0] can never be set, so only bit 1 matters for word alignment.
  assign misalign   = CHECK_WORD_ALIGN && taken && target[1];
  assign pred_wrong = (taken != bus.iPRED_TAKEN) ||
                      (taken && bus.iPRED_TAKEN && (target != bus.iPRED_TARGET));
  assign redirect   = pred_wrong && !misalign && !illegal;

  assign ready      = !valid_q || bus.iREADY;
  assign fire       = bus.iVALID && ready;
  assign bus.oREADY = ready;

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      valid_q   <= 1'b0;
      flags_q   <= '0;
      next_pc_q <= '0;
      link_q    <= '0;
    end else if (fire) begin
      valid_q           <= 1'b1;
      flags_q.taken     <= taken;
      flags_q.redirect  <= redirect;
      flags_q.misalign  <= misalign;
      flags_q.illegal   <= illegal;
      next_pc_q         <= taken ? target : pc_plus4;
      link_q            <= pc_plus4;
    end else if (bus.iREADY) begin
      valid_q <= 1'b0;
    end
  end

  // Clear wins over a same-cycle increment; both counters stick at all-ones.
  always_ff @(posedge iCLK) begin
    if (!iRST_N || bus.iCNT_CLR) begin
      br_cnt   <= '0;
      misp_cnt <= '0;
    end else begin
      if (fire && ctrl_legal && (br_cnt != '1)) begin
        br_cnt <= br_cnt + CNT_W'(1);
      end
      if (fire && redirect && (misp_cnt != '1)) begin
        misp_cnt <= misp_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.oVALID    = valid_q;
  assign bus.oTAKEN    = flags_q.taken;
  assign bus.oREDIRECT = flags_q.redirect;
  assign bus.oMISALIGN = flags_q.misalign;
  assign bus.oILLEGAL  = flags_q.illegal;
  assign bus.oNEXT_PC  = next_pc_q;
  assign bus.oLINK     = link_q;
  assign bus.oBR_CNT   = br_cnt;
  assign bus.oMISP_CNT = misp_cnt;

endmodule
